// File: rtl/cpu_wb_arbiter_if.sv
// Writeback arbiter bus: ALU/MUL requests in, register-file write port and status out.
// Forwarding lookup signals exist only when CPU_WB_ARB_FWD_EN is defined.
interface cpu_wb_arbiter_if #(
    parameter int REG_WIDTH = 32
);
    logic                 alu_valid;
    logic [4:0]           alu_reg;
    logic [REG_WIDTH-1:0] alu_data;
    logic                 mul_valid;
    logic [4:0]           mul_reg;
    logic [REG_WIDTH-1:0] mul_data;
    logic                 mul_ready;
    logic                 wr_en;
    logic [4:0]           wr_reg;
    logic [REG_WIDTH-1:0] wr_data;
    logic                 pending;
    logic                 overflow_err;
`ifdef CPU_WB_ARB_FWD_EN
    logic [4:0]           fwd_reg;
    logic                 fwd_hit;
    logic [REG_WIDTH-1:0] fwd_data;
`endif

    modport master (
        output alu_valid, alu_reg, alu_data, mul_valid, mul_reg, mul_data,
`ifdef CPU_WB_ARB_FWD_EN
        output fwd_reg,
        input  fwd_hit, fwd_data,
`endif
        input  mul_ready, wr_en, wr_reg, wr_data, pending, overflow_err
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mul_valid, mul_reg, mul_data,
`ifdef CPU_WB_ARB_FWD_EN
        input  fwd_reg,
        output fwd_hit, fwd_data,
`endif
        output mul_ready, wr_en, wr_reg, wr_data, pending, overflow_err
    );
endinterface

// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter: fixed-priority ALU, MUL results buffered in a 2-entry skid FIFO.
// Optional forwarding lookup enabled by defining CPU_WB_ARB_FWD_EN.
module cpu_wb_arbiter #(
    parameter int REG_WIDTH = 32
) (
    input  logic            clock,
    input  logic            reset,
    cpu_wb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

    cnt_e                 cnt_q, cnt_d;
    logic [4:0]           freg_q [2];
    logic [4:0]           freg_d [2];
    logic [REG_WIDTH-1:0] fdat_q [2];
    logic [REG_WIDTH-1:0] fdat_d [2];
    logic                 wr_en_q, wr_en_d;
    logic [4:0]           wr_reg_q, wr_reg_d;
    logic [REG_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                 ovf_q, ovf_d;
    logic                 accept, pop, push, direct;

    always_comb begin
        cnt_d     = cnt_q;
        freg_d    = freg_q;
        fdat_d    = fdat_q;
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        accept    = bus.mul_valid && (cnt_q != FULL);
        ovf_d     = ovf_q || (bus.mul_valid && (cnt_q == FULL));
        pop       = 1'b0;
        direct    = 1'b0;

        if (bus.alu_valid) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = bus.alu_reg;
            wr_data_d = bus.alu_data;
        end else if (cnt_q != EMPTY) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = freg_q[0];
            wr_data_d = fdat_q[0];
            pop       = 1'b1;
        end else if (accept) begin
            wr_en_d   = 1'b1;
            wr_reg_d  = bus.mul_reg;
            wr_data_d = bus.mul_data;
            direct    = 1'b1;
        end

        push = accept && !direct;

        // Entry 0 is always the head; a push lands behind whatever survives the pop.
        case ({pop, push})
            2'b10: begin
                freg_d[0] = freg_q[1];
                fdat_d[0] = fdat_q[1];
                cnt_d     = (cnt_q == FULL) ? ONE : EMPTY;
            end
            2'b01: begin
                if (cnt_q == EMPTY) begin
                    freg_d[0] = bus.mul_reg;
                    fdat_d[0] = bus.mul_data;
                    cnt_d     = ONE;
                end else begin
                    freg_d[1] = bus.mul_reg;
                    fdat_d[1] = bus.mul_data;
                    cnt_d     = FULL;
                end
            end
            2'b11: begin
                freg_d[0] = bus.mul_reg;
                fdat_d[0] = bus.mul_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= EMPTY;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO payload needs no reset: the count alone decides validity.
    always_ff @(posedge clock) begin
        freg_q <= freg_d;
        fdat_q <= fdat_d;
    end

    assign bus.mul_ready    = (cnt_q != FULL);
    assign bus.pending      = (cnt_q != EMPTY);
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_reg       = wr_reg_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.overflow_err = ovf_q;

`ifdef CPU_WB_ARB_FWD_EN
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        if ((cnt_q == FULL) && (freg_q[1] == bus.fwd_reg)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = fdat_q[1];
        end else if ((cnt_q != EMPTY) && (freg_q[0] == bus.fwd_reg)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = fdat_q[0];
        end else if (wr_en_q && (wr_reg_q == bus.fwd_reg)) begin
            bus.fwd_hit  = 1'b1;
            bus.fwd_data = wr_data_q;
        end
    end
`endif
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Scoreboard bench for cpu_wb_arbiter: directed scenarios then randomized traffic
// against a queue-based reference model.
module tb_cpu_wb_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_wb_arbiter_if #(.REG_WIDTH(W)) bus ();

    cpu_wb_arbiter #(.REG_WIDTH(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic         en;
        logic [4:0]   r;
        logic [W-1:0] d;
        logic         rdy;
        logic         pend;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [4:0]   r;
        logic [W-1:0] d;
    } ent_t;

    exp_t   exp_q[$];
    ent_t   mq[$];
    logic   m_en;
    logic [4:0]   m_reg;
    logic [W-1:0] m_data;
    logic   m_ovf;
    int     checks = 0;
    int     errors = 0;
    int     fwd_force = -1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    // One clock of stimulus; the model decides what the write port must show after the edge.
    task automatic cyc(input logic rs, input logic av, input logic [4:0] ar, input logic [W-1:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [W-1:0] md);
        exp_t e;
        ent_t n;
        logic acc;
        @(negedge clk);
        rst           = rs;
        bus.alu_valid = av;
        bus.alu_reg   = ar;
        bus.alu_data  = ad;
        bus.mul_valid = mv;
        bus.mul_reg   = mr;
        bus.mul_data  = md;
`ifdef CPU_WB_ARB_FWD_EN
        begin
            logic         hit;
            logic [W-1:0] fd;
            bus.fwd_reg = (fwd_force >= 0) ? 5'(fwd_force) : 5'($urandom_range(0, 7));
            hit = 1'b0;
            fd  = '0;
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].r == bus.fwd_reg) begin
                    hit = 1'b1;
                    fd  = mq[i].d;
                end
            end
            if (!hit && m_en && m_reg == bus.fwd_reg) begin
                hit = 1'b1;
                fd  = m_data;
            end
            #1;
            chk("fwd_hit", W'(bus.fwd_hit), W'(hit));
            chk("fwd_data", bus.fwd_data, fd);
        end
`endif
        if (rs) begin
            mq.delete();
            m_en   = 1'b0;
            m_reg  = '0;
            m_data = '0;
            m_ovf  = 1'b0;
        end else begin
            acc  = mv && (mq.size() < 2);
            if (mv && !acc) m_ovf = 1'b1;
            n.r  = mr;
            n.d  = md;
            m_en = 1'b1;
            if (av) begin
                m_reg  = ar;
                m_data = ad;
                if (acc) mq.push_back(n);
            end else if (mq.size() > 0) begin
                m_reg  = mq[0].r;
                m_data = mq[0].d;
                void'(mq.pop_front());
                if (acc) mq.push_back(n);
            end else if (acc) begin
                m_reg  = mr;
                m_data = md;
            end else begin
                m_en = 1'b0;
            end
        end
        e.en   = m_en;
        e.r    = m_reg;
        e.d    = m_data;
        e.rdy  = (mq.size() < 2);
        e.pend = (mq.size() != 0);
        e.ovf  = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'($urandom), W'($urandom), 1'b0, 5'($urandom), W'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_en", W'(bus.wr_en), W'(e.en));
                chk("wr_reg", W'(bus.wr_reg), W'(e.r));
                chk("wr_data", bus.wr_data, e.d);
                chk("mul_ready", W'(bus.mul_ready), W'(e.rdy));
                chk("pending", W'(bus.pending), W'(e.pend));
                chk("overflow_err", W'(bus.overflow_err), W'(e.ovf));
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        bus.alu_valid = 1'b0;
        bus.mul_valid = 1'b0;
        bus.alu_reg = '0;
        bus.alu_data = '0;
        bus.mul_reg = '0;
        bus.mul_data = '0;
`ifdef CPU_WB_ARB_FWD_EN
        bus.fwd_reg = '0;
`endif
        m_en = 1'b0; m_reg = '0; m_data = '0; m_ovf = 1'b0;

        cyc(1, 1, 5, 32'h55, 1, 6, 32'h66);
        cyc(1, 0, 0, 0, 1, 6, 32'h66);
        // ALU only
        cyc(0, 1, 3, 32'h11, 0, 0, 0);
        idle();
        // ALU and MUL together
        cyc(0, 1, 1, 32'hA, 1, 2, 32'hB);
        idle();
        idle();
        // ALU burst fills the FIFO
        cyc(0, 1, 8, 32'h80, 1, 4, 32'h1);
        cyc(0, 1, 8, 32'h81, 1, 5, 32'h2);
        cyc(0, 1, 8, 32'h82, 0, 0, 0);
        idle();
        idle();
        idle();
        // Overflow on full FIFO
        cyc(0, 1, 9, 32'h90, 1, 10, 32'hA0);
        cyc(0, 1, 9, 32'h91, 1, 11, 32'hA1);
        cyc(0, 1, 9, 32'h92, 1, 12, 32'hA2);
        idle();
        idle();
        idle();
        // Reset with a full FIFO
        cyc(0, 1, 13, 32'hD0, 1, 14, 32'hE0);
        cyc(0, 1, 13, 32'hD1, 1, 15, 32'hE1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle();
        idle();
        // Two pending writes to the same register
        cyc(0, 1, 2, 32'h20, 1, 7, 32'h5);
        cyc(0, 1, 3, 32'h30, 1, 7, 32'h9);
        fwd_force = 7;
        cyc(0, 1, 4, 32'h40, 0, 0, 0);
        fwd_force = -1;
        idle();
        idle();

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), W'($urandom),
                ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), W'($urandom));
        end

        @(posedge clk);
        #3;
        chk("scoreboard_drained", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
